osd_dem_uart_rx: RTL



---
 rtl/osd_dem_uart_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/osd_dem_uart_rx.sv
// Receive side of the UART debug endpoint: event packets are unpacked into a
// character FIFO, every other packet is forwarded untouched to the register interface.
module osd_dem_uart_rx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [1:0]  EVENT_TYPE = 2'b10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        debug_in_valid,
  input  logic                        debug_in_last,
  input  logic [15:0]                 debug_in_data,
  output logic                        debug_in_ready,
  output logic                        reg_out_valid,
  output logic                        reg_out_last,
  output logic [15:0]                 reg_out_data,
  input  logic                        reg_out_ready,
  output logic [7:0]                  in_char,
  output logic                        in_valid,
  input  logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [1:0]                  dbg_state
);

  // Handshake: a flit/character moves on a rising clk edge where valid and ready
  // are both high; valid never waits for ready, and payload is held while stalled.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PASS = 2'd2,
    EVT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;

  assign full       = (count_q == LW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign in_valid   = !empty;
  assign in_char    = mem_q[rd_ptr_q];
  assign fifo_level = count_q;
  assign dbg_state  = state_q;
  assign pop        = in_valid && in_ready;

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    debug_in_ready = 1'b0;
    reg_out_valid  = 1'b0;
    reg_out_last   = 1'b0;
    reg_out_data   = hold_q;
    push           = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          debug_in_ready = 1'b1;
          if (debug_in_valid) begin
            hold_d = debug_in_data;
            // A lone destination flit carries nothing and is simply dropped.
            if (!debug_in_last) state_d = HDR;
          end
        end
        HDR: begin
          if (debug_in_valid && (debug_in_data[15:14] == EVENT_TYPE)) begin
            debug_in_ready = 1'b1;
            state_d        = debug_in_last ? IDLE : EVT;
          end else begin
            // Replay the held destination flit before streaming the rest through.
            reg_out_valid = 1'b1;
            reg_out_data  = hold_q;
            reg_out_last  = 1'b0;
            if (reg_out_ready) state_d = PASS;
          end
        end
        PASS: begin
          reg_out_valid  = debug_in_valid;
          reg_out_last   = debug_in_last;
          reg_out_data   = debug_in_data;
          debug_in_ready = reg_out_ready;
          if (debug_in_valid && reg_out_ready && debug_in_last) state_d = IDLE;
        end
        EVT: begin
          // No bypass when full: a pop this cycle only frees space for the next one.
          debug_in_ready = !full;
          if (debug_in_valid && !full) begin
            push = 1'b1;
            if (debug_in_last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= debug_in_data[7:0];
  end

endmodule
